noise_ctrl: RTL and testbench

NOISE_CTRL -- requirements
Module: noise_ctrl

---
 rtl/noise_ctrl.sv | 162 ++++++++++++++++
 tb/tb_noise_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/noise_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | noise_ctrl: noise-channel register file (NR41..NR44), frame sequencer     |
// | and length/envelope tick generation. Option: NOISE_CTRL_READBACK_EN.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module noise_ctrl #(
  parameter int DIV = 8192
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       power_en,
  input  logic       wr_en,
  input  logic [1:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       rd_en,
  input  logic [1:0] rd_addr,
  output logic [7:0] rd_data,
  output logic [5:0] len_load,
  output logic [3:0] start_vol,
  output logic       env_add,
  output logic [2:0] env_period,
  output logic [3:0] clk_shift,
  output logic       width_mode,
  output logic [2:0] divisor,
  output logic       len_enable,
  output logic       trigger,
  output logic       len_tick,
  output logic       env_tick
);

  localparam logic [15:0] c_last    = 16'(DIV - 1);
  localparam logic [1:0]  c_addr_41 = 2'd0;
  localparam logic [1:0]  c_addr_42 = 2'd1;
  localparam logic [1:0]  c_addr_43 = 2'd2;
  localparam logic [1:0]  c_addr_44 = 2'd3;

  logic [15:0] r_presc;
  logic [2:0]  r_step;
  logic        r_armed;
  logic        r_len_tick;
  logic        r_env_tick;
  logic [5:0]  r_nr41;
  logic [7:0]  r_nr42;
  logic [7:0]  r_nr43;
  logic        r_len_en;
  logic        r_trigger;
  logic [7:0]  r_rd_data;

  logic        w_strobe;
  logic [2:0]  w_step_nxt;
  logic        w_trig_wr;

  assign w_strobe   = (r_presc == c_last);
  assign w_step_nxt = r_step + 3'd1;
  assign w_trig_wr  = wr_en && (wr_addr == c_addr_44) && wr_data[7];

  // Frame sequencer. Length ticks stay suppressed until the step counter has
  // wrapped to 0 once after power-up, so the first one lands 8 steps in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc    <= '0;
      r_step     <= '0;
      r_armed    <= 1'b0;
      r_len_tick <= 1'b0;
      r_env_tick <= 1'b0;
    end else if (!power_en) begin
      r_presc    <= '0;
      r_step     <= '0;
      r_armed    <= 1'b0;
      r_len_tick <= 1'b0;
      r_env_tick <= 1'b0;
    end else begin
      r_presc <= w_strobe ? 16'd0 : r_presc + 16'd1;
      if (w_strobe) begin
        r_step <= w_step_nxt;
      end
      if (w_strobe && (w_step_nxt == 3'd0)) begin
        r_armed <= 1'b1;
      end
      r_len_tick <= w_strobe && !w_step_nxt[0] && (r_armed || (w_step_nxt == 3'd0));
      r_env_tick <= w_strobe && (w_step_nxt == 3'd7);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_nr41    <= '0;
      r_nr42    <= '0;
      r_nr43    <= '0;
      r_len_en  <= 1'b0;
      r_trigger <= 1'b0;
    end else if (!power_en) begin
      r_nr41    <= '0;
      r_nr42    <= '0;
      r_nr43    <= '0;
      r_len_en  <= 1'b0;
      r_trigger <= 1'b0;
    end else begin
      r_trigger <= w_trig_wr;
      if (wr_en) begin
        case (wr_addr)
          c_addr_41: r_nr41   <= wr_data[5:0];
          c_addr_42: r_nr42   <= wr_data;
          c_addr_43: r_nr43   <= wr_data;
          default:   r_len_en <= wr_data[6];
        endcase
      end
    end
  end

`ifdef NOISE_CTRL_READBACK_EN
  logic [7:0] w_rd_val;

  // Unimplemented bits read back as 1.
  always_comb begin
    w_rd_val = 8'hFF;
    case (rd_addr)
      c_addr_41: w_rd_val = {2'b00, r_nr41} | 8'hFF;
      c_addr_42: w_rd_val = r_nr42;
      c_addr_43: w_rd_val = r_nr43;
      default:   w_rd_val = {1'b0, r_len_en, 6'b000000} | 8'hBF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= '0;
    end else if (!power_en) begin
      r_rd_data <= '0;
    end else if (rd_en) begin
      r_rd_data <= w_rd_val;
    end
  end
`else
  logic w_unused_rd;
  assign w_unused_rd = ^{rd_en, rd_addr};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= 8'hFF;
    end
  end
`endif

  assign rd_data    = r_rd_data;
  assign len_load   = r_nr41;
  assign start_vol  = r_nr42[7:4];
  assign env_add    = r_nr42[3];
  assign env_period = r_nr42[2:0];
  assign clk_shift  = r_nr43[7:4];
  assign width_mode = r_nr43[3];
  assign divisor    = r_nr43[2:0];
  assign len_enable = r_len_en;
  assign trigger    = r_trigger;
  assign len_tick   = r_len_tick;
  assign env_tick   = r_env_tick;

endmodule
`default_nettype wire

// File: tb/tb_noise_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_noise_ctrl: scoreboard bench for noise_ctrl with DIV=4.               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_noise_ctrl;

`ifdef NOISE_CTRL_READBACK_EN
  localparam logic RB = 1'b1;
`else
  localparam logic RB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, power_en, wr_en, rd_en;
  logic [1:0] wr_addr, rd_addr;
  logic [7:0] wr_data, rd_data;
  logic [5:0] len_load;
  logic [3:0] start_vol, clk_shift;
  logic       env_add, width_mode, len_enable, trigger, len_tick, env_tick;
  logic [2:0] env_period, divisor;

  noise_ctrl #(.DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .power_en(power_en),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .len_load(len_load), .start_vol(start_vol), .env_add(env_add),
    .env_period(env_period), .clk_shift(clk_shift), .width_mode(width_mode),
    .divisor(divisor), .len_enable(len_enable), .trigger(trigger),
    .len_tick(len_tick), .env_tick(env_tick)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; int sel; logic [7:0] val; } exp_t;
  typedef struct { int cyc; int kind; } pls_t;
  exp_t exq[$];
  pls_t pq[$];
  int checks = 0;
  int fails  = 0;

  function automatic logic [7:0] sig(int s);
    case (s)
      0:  return {2'b00, len_load};
      1:  return {4'h0, start_vol};
      2:  return {7'h0, env_add};
      3:  return {5'h0, env_period};
      4:  return {4'h0, clk_shift};
      5:  return {7'h0, width_mode};
      6:  return {5'h0, divisor};
      7:  return {7'h0, len_enable};
      8:  return rd_data;
      9:  return {7'h0, trigger};
      10: return {7'h0, len_tick};
      default: return {7'h0, env_tick};
    endcase
  endfunction

  function automatic string sname(int s);
    case (s)
      0: return "len_load";   1: return "start_vol";  2: return "env_add";
      3: return "env_period"; 4: return "clk_shift";  5: return "width_mode";
      6: return "divisor";    7: return "len_enable"; 8: return "rd_data";
      9: return "trigger";    10: return "len_tick";  default: return "env_tick";
    endcase
  endfunction

  // Monitor: level checks due this cycle, then pulse matching per pulse kind.
  always @(negedge clk) begin
    int hit;
    for (int i = exq.size() - 1; i >= 0; i--) begin
      if (exq[i].cyc < cyc) begin
        fails++;
        $display("FAIL %s cycle %0d: check never evaluated", sname(exq[i].sel), exq[i].cyc);
        exq.delete(i);
      end else if (exq[i].cyc == cyc) begin
        checks++;
        if (sig(exq[i].sel) !== exq[i].val) begin
          fails++;
          $display("FAIL %s cycle %0d: got %02h expected %02h", sname(exq[i].sel), cyc,
                   sig(exq[i].sel), exq[i].val);
        end
        exq.delete(i);
      end
    end
    for (int k = 0; k < 3; k++) begin
      for (int i = pq.size() - 1; i >= 0; i--) begin
        if (pq[i].kind == k && pq[i].cyc < cyc) begin
          checks++;
          fails++;
          $display("FAIL %s pulse: got none at cycle %0d expected 1", sname(9 + k), pq[i].cyc);
          pq.delete(i);
        end
      end
      hit = -1;
      for (int i = 0; i < pq.size(); i++) begin
        if (pq[i].kind == k && pq[i].cyc == cyc) hit = i;
      end
      if (sig(9 + k) != 8'h00) begin
        checks++;
        if (hit >= 0) begin
          pq.delete(hit);
        end else begin
          fails++;
          $display("FAIL %s pulse: got 1 at cycle %0d expected 0", sname(9 + k), cyc);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(int c, int s, logic [7:0] v);
    exp_t e;
    e.cyc = c; e.sel = s; e.val = v;
    exq.push_back(e);
  endtask

  // kind: 0 trigger, 1 len_tick, 2 env_tick
  task automatic pulse(int c, int k);
    pls_t p;
    p.cyc = c; p.kind = k;
    pq.push_back(p);
  endtask

  task automatic wr(logic [1:0] a, logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic rd(logic [1:0] a);
    rd_en = 1'b1; rd_addr = a;
    step();
    rd_en = 1'b0;
  endtask

  int r, p, r2, r3;

  initial begin
    rst_n = 1'b0; power_en = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_en = 1'b0; rd_addr = '0;
    repeat (3) step();
    for (int s = 0; s < 12; s++) chk(cyc, s, 8'h00);
    rst_n = 1'b1; power_en = 1'b1; r = cyc;

    // Sequencer restarts at r: env at step 7, len from the first wrap onward.
    pulse(r + 28, 2); pulse(r + 60, 2); pulse(r + 92, 2);
    for (int c = r + 32; c <= r + 96; c += 8) pulse(c, 1);

    step();
    chk(r + 2, 4, 8'h0A); chk(r + 2, 5, 8'h00); chk(r + 2, 6, 8'h05);
    wr(2'd2, 8'hA5);
    chk(r + 3, 1, 8'h0F); chk(r + 3, 2, 8'h00); chk(r + 3, 3, 8'h03);
    wr(2'd1, 8'hF3);
    chk(r + 4, 0, 8'h3F);
    wr(2'd0, 8'h3F);
    pulse(r + 5, 0); chk(r + 5, 7, 8'h01); chk(r + 6, 9, 8'h00); chk(r + 6, 7, 8'h01);
    wr(2'd3, 8'hC0);
    step();
    pulse(r + 7, 0); pulse(r + 8, 0); chk(r + 7, 7, 8'h00); chk(r + 9, 9, 8'h00);
    wr(2'd3, 8'h80);
    wr(2'd3, 8'h80);

    chk(r + 9, 8, RB ? 8'hBF : 8'hFF);
    rd(2'd3);
    chk(r + 10, 7, 8'h01);
    wr(2'd3, 8'h40);
    chk(r + 11, 8, 8'hFF);
    rd(2'd3);
    chk(r + 12, 8, 8'hFF);
    rd(2'd0);
    chk(r + 13, 1, 8'h09); chk(r + 13, 2, 8'h00); chk(r + 13, 3, 8'h03);
    wr(2'd1, 8'h93);
    chk(r + 14, 8, RB ? 8'h93 : 8'hFF);
    rd(2'd1);
    chk(r + 15, 8, RB ? 8'hA5 : 8'hFF); chk(r + 15, 4, 8'h01); chk(r + 15, 6, 8'h02);
    rd_en = 1'b1; rd_addr = 2'd2; wr_en = 1'b1; wr_addr = 2'd2; wr_data = 8'h12;
    step();
    rd_en = 1'b0; wr_en = 1'b0;
    chk(r + 16, 8, RB ? 8'hA5 : 8'hFF);
    step();

    // Trigger lands on the same cycle as the first length tick.
    while (cyc < r + 31) step();
    pulse(r + 32, 0);
    wr(2'd3, 8'hC0);

    while (cyc < r + 98) step();
    chk(r + 99, 1, 8'h0F); chk(r + 99, 3, 8'h03);
    wr(2'd1, 8'hF3);
    step();

    // One cycle of power-off with a write that must be ignored.
    p = cyc;
    power_en = 1'b0; wr_en = 1'b1; wr_addr = 2'd1; wr_data = 8'hF3;
    chk(p + 1, 1, 8'h00); chk(p + 1, 3, 8'h00); chk(p + 1, 4, 8'h00);
    chk(p + 1, 7, 8'h00); chk(p + 1, 0, 8'h00); chk(p + 1, 8, RB ? 8'h00 : 8'hFF);
    step();
    wr_en = 1'b0; power_en = 1'b1; r2 = cyc;
    chk(r2 + 1, 1, 8'h00); chk(r2 + 1, 3, 8'h00);
    pulse(r2 + 28, 2); pulse(r2 + 32, 1); pulse(r2 + 40, 1);
    step();
    chk(r2 + 3, 4, 8'h0A);
    wr(2'd2, 8'hA5);
    chk(r2 + 4, 0, 8'h3F);
    wr(2'd0, 8'h3F);

    // Asynchronous reset in the middle of a trigger pulse.
    while (cyc < r2 + 44) step();
    chk(r2 + 45, 9, 8'h00); chk(r2 + 45, 7, 8'h00); chk(r2 + 45, 4, 8'h00);
    chk(r2 + 45, 0, 8'h00); chk(r2 + 45, 8, 8'h00); chk(r2 + 45, 10, 8'h00);
    wr(2'd3, 8'hC0);
    #2 rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1; r3 = cyc;
    chk(r3 + 1, 8, RB ? 8'h00 : 8'hFF);
    pulse(r3 + 28, 2); pulse(r3 + 60, 2);
    for (int c = r3 + 32; c <= r3 + 64; c += 8) pulse(c, 1);
    while (cyc < r3 + 71) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
